// File: rtl/spi_pkg.sv
// Shared state encoding, SPI mode constants and sizing helper for the SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_e;

    // Modes are encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int unsigned edge_cnt_w(input int unsigned data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for sclk; o_tick pulses for one clk every CLK_DIV enabled cycles.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tick
);
    localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    // Counter sits at zero while disabled so the first tick after a restart is a full half-period away
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || !i_en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && !i_restart && w_wrap;

endmodule

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with configurable width, mode, bit order, sclk divider and CS gap.
// sclk is a registered data output of the clk domain; nothing is clocked by it.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned CLK_DIV   = 11,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CS_GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso,
    output logic [DATA_W-1:0] dout,
    output logic              done
);
    localparam logic [1:0]    MODE        = {CPOL, CPHA};
    localparam bit            SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
    localparam bit            SHIFT_LEAD  = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
    localparam int unsigned   EW          = edge_cnt_w(DATA_W);
    localparam logic [EW-1:0] LAST_EDGE   = EW'(2 * DATA_W);
    localparam int unsigned   GW          = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST    = GW'(CS_GAP - 1);

    generate
        if (DATA_W < 2 || CLK_DIV < 1 || CS_GAP < 1) begin : g_bad_param
            $error("spi_master_cfg: need DATA_W>=2, CLK_DIV>=1, CS_GAP>=1");
        end
    endgenerate

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    spi_state_e        r_state;
    logic [EW-1:0]     r_edge;
    logic [GW-1:0]     r_gap;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              r_sclk;
    logic              r_cs;
    logic              r_mosi;
    logic [DATA_W-1:0] r_dout;
    logic              r_done;

    logic              w_accept;
    logic              w_div_en;
    logic              w_tick;
    logic [EW-1:0]     w_edge_nxt;
    logic              w_lead;
    logic              w_sample;
    logic              w_shift;

    assign w_accept   = newd && (r_state == IDLE);
    assign w_div_en   = (r_state == SETUP) || (r_state == XFER) || (r_state == HOLD);
    assign w_edge_nxt = r_edge + 1'b1;
    assign w_lead     = w_edge_nxt[0];
    assign w_sample   = SAMPLE_LEAD ? w_lead : !w_lead;
    // With CPHA=0 the first bit is already on mosi at cs fall, so the final trailing edge has nothing to shift
    assign w_shift    = SHIFT_LEAD ? w_lead : (!w_lead && (w_edge_nxt != LAST_EDGE));

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_restart(w_accept),
        .i_en     (w_div_en),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_edge  <= '0;
            r_gap   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sclk  <= CPOL;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
            r_dout  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SETUP;
                        r_cs    <= 1'b0;
                        r_edge  <= '0;
                        r_rx    <= '0;
                        if (SHIFT_LEAD) begin
                            r_tx <= din;
                        end else begin
                            r_mosi <= first_bit(din);
                            r_tx   <= shift_out(din);
                        end
                    end
                end
                SETUP, XFER: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_nxt;
                        if (w_sample) begin
                            r_rx <= shift_in(r_rx, miso);
                        end
                        if (w_shift) begin
                            r_mosi <= first_bit(r_tx);
                            r_tx   <= shift_out(r_tx);
                        end
                        r_state <= (w_edge_nxt == LAST_EDGE) ? HOLD : XFER;
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state <= GAP;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_dout  <= r_rx;
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign sclk  = r_sclk;
    assign cs    = r_cs;
    assign mosi  = r_mosi;
    assign dout  = r_dout;
    assign done  = r_done;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: three configurations, bit-level SPI slave models, table and random frames.
module tb_spi_master_cfg;
    localparam int AD = 12, AC = 2, BD = 12, BC = 2, CD = 8, CC = 1, GAPC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // A: mode 0, LSB first; B: mode 3, MSB first; C: mode 1, 8 bit, CLK_DIV=1
    logic a_newd = 1'b0, a_ready, a_sclk, a_cs, a_mosi, a_miso, a_done;
    logic [11:0] a_din = '0, a_dout;
    logic b_newd = 1'b0, b_ready, b_sclk, b_cs, b_mosi, b_miso = 1'b0, b_done;
    logic [11:0] b_din = '0, b_dout;
    logic c_newd = 1'b0, c_ready, c_sclk, c_cs, c_mosi, c_miso, c_done;
    logic [7:0] c_din = '0, c_dout;

    logic a_loop = 1'b1, a_smiso = 1'b0;
    assign a_miso = a_loop ? a_mosi : a_smiso;
    assign c_miso = c_mosi;

    spi_master_cfg #(.DATA_W(AD), .CLK_DIV(AC), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1), .CS_GAP(GAPC)) u_a (
        .clk(clk), .rst(rst), .newd(a_newd), .din(a_din), .ready(a_ready), .sclk(a_sclk),
        .cs(a_cs), .mosi(a_mosi), .miso(a_miso), .dout(a_dout), .done(a_done));
    spi_master_cfg #(.DATA_W(BD), .CLK_DIV(BC), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0), .CS_GAP(GAPC)) u_b (
        .clk(clk), .rst(rst), .newd(b_newd), .din(b_din), .ready(b_ready), .sclk(b_sclk),
        .cs(b_cs), .mosi(b_mosi), .miso(b_miso), .dout(b_dout), .done(b_done));
    spi_master_cfg #(.DATA_W(CD), .CLK_DIV(CC), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1), .CS_GAP(GAPC)) u_c (
        .clk(clk), .rst(rst), .newd(c_newd), .din(c_din), .ready(c_ready), .sclk(c_sclk),
        .cs(c_cs), .mosi(c_mosi), .miso(c_miso), .dout(c_dout), .done(c_done));

    // Slave A, mode 0 LSB first: present bit 0 at cs fall, capture on rising sclk, present next on falling
    logic [11:0] a_sw = '0, a_scap = '0;
    int a_ti = 0, a_ri = 0;
    always @(negedge a_cs) begin a_ti = 0; a_ri = 0; a_scap = '0; a_smiso = a_sw[0]; end
    always @(posedge a_cs) a_smiso = 1'b0;
    always @(posedge a_sclk) if (a_cs === 1'b0 && a_ri < 12) begin a_scap[a_ri] = a_mosi; a_ri++; end
    always @(negedge a_sclk) if (a_cs === 1'b0) begin a_ti++; if (a_ti < 12) a_smiso = a_sw[a_ti]; end

    // Slave B, mode 3 MSB first: present on falling (leading) sclk, capture on rising (trailing)
    logic [11:0] b_sw = '0, b_scap = '0;
    int b_ti = 0, b_ri = 0;
    always @(negedge b_cs) begin b_ti = 0; b_ri = 0; b_scap = '0; end
    always @(posedge b_cs) b_miso = 1'b0;
    always @(negedge b_sclk) if (b_cs === 1'b0 && b_ti < 12) begin b_miso = b_sw[11-b_ti]; b_ti++; end
    always @(posedge b_sclk) if (b_cs === 1'b0 && b_ri < 12) begin b_scap[11-b_ri] = b_mosi; b_ri++; end

    int a_done_n = 0, a_cslow = 0, a_cshigh = 0, a_last_low = 0, a_last_high = 0;
    int a_rise = 0, a_edges = 0, b_fall = 0, c_edges = 0, mosi_bad = 0;
    logic a_cs_q = 1'b1;
    always @(posedge a_sclk) if (a_cs === 1'b0) a_rise++;
    always @(a_sclk) if (a_cs === 1'b0) a_edges++;
    always @(negedge b_sclk) if (b_cs === 1'b0) b_fall++;
    always @(c_sclk) if (c_cs === 1'b0) c_edges++;
    always @(negedge clk) begin
        if (a_done === 1'b1) a_done_n++;
        if (a_cs === 1'b0) begin
            a_cslow++;
            if (a_cs_q) begin a_last_high = a_cshigh; a_cshigh = 0; end
        end else begin
            a_cshigh++;
            if (!a_cs_q) begin a_last_low = a_cslow; a_cslow = 0; end
        end
        a_cs_q = (a_cs !== 1'b0);
        if ((a_cs === 1'b1 && a_mosi !== 1'b0) || (b_cs === 1'b1 && b_mosi !== 1'b0) ||
            (c_cs === 1'b1 && c_mosi !== 1'b0)) mosi_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        case (w)
            0: return a_ready;
            1: return b_ready;
            default: return c_ready;
        endcase
    endfunction

    function automatic logic dn(input int w);
        case (w)
            0: return a_done;
            1: return b_done;
            default: return c_done;
        endcase
    endfunction

    task automatic req(input int w, input logic v, input logic [11:0] d);
        case (w)
            0: begin a_newd = v; a_din = d; end
            1: begin b_newd = v; b_din = d; end
            default: begin c_newd = v; c_din = d[7:0]; end
        endcase
    endtask

    // One frame; lat counts cycles from the accept cycle (counted as 1) to the done cycle, -1 on timeout
    task automatic run(input int w, input logic [11:0] d, output int lat);
        int n, t;
        t = 0;
        while (rdy(w) !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        req(w, 1'b1, d);
        n = cyc;
        @(negedge clk);
        req(w, 1'b0, ~d);
        t = 0;
        while (dn(w) !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        lat = (dn(w) === 1'b1) ? (cyc - n) : -1;
        @(negedge clk);
    endtask

    task automatic wait_sig(input int w, input bit want_done, input logic lvl);
        int t;
        t = 0;
        while (((want_done ? dn(w) : rdy(w)) !== lvl) && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) check("wait_timeout", 32'(t), 32'd0);
    endtask

    typedef struct {
        logic [11:0] din;
        logic [11:0] sw;
        bit          loop;
        logic [11:0] exp_dout;
        logic [11:0] exp_cap;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0;
        logic [11:0] r, s;
        vecs[0] = '{12'hA5C, 12'h000, 1'b1, 12'hA5C, 12'hA5C};
        vecs[1] = '{12'h000, 12'hFFF, 1'b0, 12'hFFF, 12'h000};
        vecs[2] = '{12'hFFF, 12'h000, 1'b0, 12'h000, 12'hFFF};
        vecs[3] = '{12'h001, 12'h800, 1'b0, 12'h800, 12'h001};
        vecs[4] = '{12'h800, 12'h001, 1'b0, 12'h001, 12'h800};
        vecs[5] = '{12'h5A5, 12'hA5A, 1'b0, 12'hA5A, 12'h5A5};

        @(negedge clk);
        check("rst_a_cs", a_cs, 1); check("rst_a_sclk", a_sclk, 0); check("rst_b_sclk", b_sclk, 1);
        check("rst_a_mosi", a_mosi, 0); check("rst_a_dout", a_dout, 0); check("rst_a_done", a_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", a_ready, 1);

        for (int i = 0; i < 6; i++) begin
            a_loop = vecs[i].loop; a_sw = vecs[i].sw; a_rise = 0; d0 = a_done_n;
            run(0, vecs[i].din, lat);
            check($sformatf("v%0d_dout", i), a_dout, vecs[i].exp_dout);
            check($sformatf("v%0d_cap", i), a_scap, vecs[i].exp_cap);
            check($sformatf("v%0d_lat", i), lat, 1 + (2 * AD + 1) * AC);
            check($sformatf("v%0d_cslow", i), a_last_low, (2 * AD + 1) * AC);
            check($sformatf("v%0d_rises", i), a_rise, AD);
            check($sformatf("v%0d_dones", i), a_done_n - d0, 1);
        end

        for (int i = 0; i < 12; i++) begin
            r = 12'($urandom); s = 12'($urandom);
            a_loop = 1'b0; a_sw = s;
            run(0, r, lat);
            check($sformatf("rndA%0d_dout", i), a_dout, s);
            check($sformatf("rndA%0d_cap", i), a_scap, r);
        end

        // Mode 3 MSB first against slave B
        check("b_idle_sclk_before", b_sclk, 1);
        b_sw = 12'h3F0; b_fall = 0;
        run(1, 12'h0C3, lat);
        check("b_cap", b_scap, 12'h0C3); check("b_dout", b_dout, 12'h3F0);
        check("b_idle_sclk_after", b_sclk, 1); check("b_lat", lat, 1 + (2 * BD + 1) * BC);
        check("b_leading_edges", b_fall, BD);
        for (int i = 0; i < 6; i++) begin
            r = 12'($urandom); s = 12'($urandom); b_sw = s;
            run(1, r, lat);
            check($sformatf("rndB%0d_dout", i), b_dout, s);
            check($sformatf("rndB%0d_cap", i), b_scap, r);
        end

        // newd held high across two frames
        a_loop = 1'b1; d0 = a_done_n;
        wait_sig(0, 1'b0, 1'b1);
        req(0, 1'b1, 12'h111);
        wait_sig(0, 1'b0, 1'b0);
        req(0, 1'b1, 12'h222);
        wait_sig(0, 1'b1, 1'b1);
        check("held_first_dout", a_dout, 12'h111);
        wait_sig(0, 1'b0, 1'b1);
        wait_sig(0, 1'b0, 1'b0);
        req(0, 1'b0, 12'h000);
        wait_sig(0, 1'b1, 1'b1);
        check("held_second_dout", a_dout, 12'h222);
        @(negedge clk);
        check("held_cs_gap", a_last_high, GAPC + 1);
        check("held_dones", a_done_n - d0, 2);

        // request while busy is dropped
        repeat (5) @(negedge clk);
        d0 = a_done_n;
        req(0, 1'b1, 12'h123); @(negedge clk); req(0, 1'b0, 12'h123);
        repeat (20) @(negedge clk);
        req(0, 1'b1, 12'hFFF); @(negedge clk); req(0, 1'b0, 12'hFFF);
        wait_sig(0, 1'b1, 1'b1);
        check("busy_dout", a_dout, 12'h123);
        repeat (20) @(negedge clk);
        check("busy_dones", a_done_n - d0, 1);
        check("busy_cap", a_scap, 12'h123);
        check("busy_cs_idle", a_cs, 1);

        // asynchronous reset after sclk edge 7
        a_edges = 0;
        req(0, 1'b1, 12'h3C3); @(negedge clk); req(0, 1'b0, 12'h3C3);
        for (int t = 0; t < 100 && a_edges < 7; t++) @(negedge clk);
        check("rst_mid_edges", a_edges, 7);
        d0 = a_done_n;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_cs", a_cs, 1); check("rst_mid_sclk", a_sclk, 0);
        check("rst_mid_mosi", a_mosi, 0); check("rst_mid_dout", a_dout, 0); check("rst_mid_done", a_done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_ready", a_ready, 1);
        check("rst_mid_no_done", a_done_n - d0, 0);
        run(0, 12'h5A5, lat);
        check("post_rst_dout", a_dout, 12'h5A5);
        check("post_rst_lat", lat, 1 + (2 * AD + 1) * AC);

        // CLK_DIV=1, 8 bit, mode 1 loopback
        c_edges = 0;
        run(2, 12'h081, lat);
        check("c_dout", c_dout, 8'h81);
        check("c_lat", lat, 1 + (2 * CD + 1) * CC);
        check("c_edges", c_edges, 2 * CD);
        for (int i = 0; i < 6; i++) begin
            r = 12'($urandom);
            run(2, r, lat);
            check($sformatf("rndC%0d_dout", i), c_dout, r[7:0]);
            check($sformatf("rndC%0d_lat", i), lat, 1 + (2 * CD + 1) * CC);
        end

        check("mosi_zero_when_cs_high", mosi_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
